adc_chain_node: RTL
===================

Name: adc_chain_node

Overview:
- Parametrised daisy-chain readout node for the per-row ADC block chain. Generalises the fixed 4-channel/12-bit chain node to CH_NUM channels and BITS_ADC width.
- Captures one sample per channel on each ADC-ready edge and shifts them down the chain behind upstream words.
- New relative to the previous node: optional delta encoding (saturated), an overrun counter and a busy indicator.
- N instances are cascaded; the head's data_from_pre is tied to all-ones (idle) and the tail feeds the row serializer.

Parameters:
- BITS_ADC, 12: ADC sample width; chain word is BITS_ADC+1 bits.
- CH_NUM, 4: channels per node, and the shift-register depth (at least 1).
- CNT_W, 8: overrun counter width.

Ports:
- clk  in  1  node clock (clk_3p2M domain).
- rst  in  1  synchronous reset, active high.
- adc_ready  in  1  ADC conversion done; its rising edge loads samples.
- adc_data  in  CH_NUM*BITS_ADC  samples, channel k at [k*BITS_ADC +: BITS_ADC]; unsigned; stable on the load edge.
- mode_delta  in  1  0 = raw samples, 1 = delta vs previous sample of the same channel.
- shift_en  in  1  chain shift strobe, common to all nodes.
- data_from_pre  in  BITS_ADC+1  word from the upstream node.
- data_to_post  out  BITS_ADC+1  word to the downstream node.
- busy  out  1  local words not yet fully shifted out.
- overrun_cnt  out  CNT_W  number of loads that arrived while busy.

Behaviour:
- Word format: {flag, payload}.
  - flag = 0: data word.
  - All-ones: idle word. A raw payload of all-ones with flag 0 is a legal data word.
- Reset (rst high at a posedge clk):
  - sr[0..CH_NUM-1], and therefore data_to_post, = all-ones.
  - prev[ch] = 0, adc_ready_d = 0, shift count = 0, busy = 0, overrun_cnt = 0.
  - Reset overrides load and shift in the same cycle. Reset mid-shift discards the frame.
- Edge detect:
  - adc_ready_d is a registered copy of adc_ready.
  - load = adc_ready & ~adc_ready_d, evaluated at the sampling edge.
  - A level held high produces exactly one load.
- Load (at the edge where load = 1):
  - sr[CH_NUM-1-k] <= {1'b0, word_k}, so channel 0 appears on data_to_post the cycle after the edge.
  - Shift count <= 0, busy <= 1.
  - prev[k] <= adc_data channel k on every load, in either mode.
  - mode_delta is sampled at the load edge only.
- Word computation:
  - Raw mode: word_k = sample_k.
  - Delta mode: d = sample_k - prev[k], computed at BITS_ADC+1 bits signed.
  - d is saturated to [-2^(BITS_ADC-1), 2^(BITS_ADC-1)-1] and emitted as BITS_ADC-bit two's complement.
- Shift (shift_en = 1 and load = 0):
  - sr[0] <= data_from_pre; sr[k] <= sr[k-1].
  - Shift count increments, saturating at CH_NUM. busy <= 0 when the count reaches CH_NUM.
  - With shift_en = 0, sr holds.
- Simultaneous load and shift: load wins; that shift is dropped.
- Overrun:
  - A load while busy = 1 increments overrun_cnt, saturating at 2^CNT_W-1.
  - The load still completes: the new frame overwrites the unsent words.
- Latency: one cycle from the load edge to the first word. Upstream words follow the local words after CH_NUM shifts.
- Chain of N nodes: the tail emits N*CH_NUM data words per frame with N*CH_NUM shifts, ordered from the node nearest the tail, ch0 first; after that the tail emits idle words.

Test Plan:
- Reset then raw load of ch0..3 = 0x001, 0x002, 0x003, 0xFFF, then 4 shifts with data_from_pre = all-ones -> data_to_post: 0x001 the cycle after load, then 0x002, 0x003, 0xFFF (flag 0), then 0x1FFF. busy falls after the 4th shift.
- Delta mode, first load ch0 = 0xFFF after reset -> word 0x7FF (saturated). Second load ch0 = 0x000 -> 0x800 (saturated). Third load ch0 = 0x010 -> 0x010.
- Second adc_ready rise after only 2 shifts -> overrun_cnt = 1 and the new frame is emitted. With CNT_W = 2, 5 overruns -> overrun_cnt = 3.
- Load and shift_en asserted in the same cycle -> loaded frame intact, shift count 0, upstream word not accepted.
- 3-node chain, 12 shifts after a common load -> tail emits the 12 data words in node/channel order, then 0x1FFF.
- rst asserted mid-shift with adc_ready held high -> all outputs at reset values next cycle. No load until adc_ready falls and rises again.

Source files
------------

// File: rtl/adc_chain_node.sv
// adc_chain_node: one node of the per-row ADC readout daisy chain.
// On each rising edge of adc_ready it captures one sample per channel.
// Each sample is kept as is or delta-encoded against the previous sample.
// The words are then shifted toward data_to_post ahead of the upstream words.
// Word format is {flag, payload}: flag 0 marks a data word, all-ones is idle.
module adc_chain_node #(
  parameter int BITS_ADC = 12,
  parameter int CH_NUM   = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adc_ready,
  input  logic [CH_NUM*BITS_ADC-1:0] adc_data,
  input  logic                       mode_delta,
  input  logic                       shift_en,
  input  logic [BITS_ADC:0]          data_from_pre,
  output logic [BITS_ADC:0]          data_to_post,
  output logic                       busy,
  output logic [CNT_W-1:0]           overrun_cnt
);

  localparam int W    = BITS_ADC + 1;
  localparam int SC_W = $clog2(CH_NUM + 1);

  logic [W-1:0]        sr_reg   [CH_NUM];
  logic [BITS_ADC-1:0] prev_reg [CH_NUM];
  logic [BITS_ADC-1:0] sample   [CH_NUM];
  logic [BITS_ADC-1:0] word     [CH_NUM];

  logic            adc_ready_d_reg;
  logic            armed_reg;
  logic            load;
  logic [SC_W-1:0] shift_cnt_reg;
  logic            busy_reg;
  logic [CNT_W-1:0] overrun_cnt_reg;

  // adc_ready_d_reg is only meaningful after one post-reset sample.
  // armed_reg blocks a false edge when adc_ready is already high as reset
  // releases, so a level held across reset does not reload the node.
  assign load = adc_ready & ~adc_ready_d_reg & armed_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic signed [W-1:0] diff;

      assign sample[gi] = adc_data[gi*BITS_ADC +: BITS_ADC];

      // Compute the channel word: the raw sample, or the saturated delta.
      always_comb begin
        diff = $signed({1'b0, sample[gi]}) - $signed({1'b0, prev_reg[gi]});
        word[gi] = sample[gi];
        if (mode_delta) begin
          // The top two bits of the W-bit difference disagree exactly when
          // the value is outside the BITS_ADC-bit two's complement range.
          if (diff[W-1:W-2] == 2'b01) begin
            word[gi] = {1'b0, {(BITS_ADC-1){1'b1}}};
          end else if (diff[W-1:W-2] == 2'b10) begin
            word[gi] = {1'b1, {(BITS_ADC-1){1'b0}}};
          end else begin
            word[gi] = diff[BITS_ADC-1:0];
          end
        end
      end
    end
  endgenerate

  // Edge detect, frame load, chain shift, busy tracking and overrun counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) begin
        sr_reg[k]   <= '1;
        prev_reg[k] <= '0;
      end
      adc_ready_d_reg <= 1'b0;
      armed_reg       <= 1'b0;
      shift_cnt_reg   <= '0;
      busy_reg        <= 1'b0;
      overrun_cnt_reg <= '0;
    end else begin
      adc_ready_d_reg <= adc_ready;
      armed_reg       <= 1'b1;
      if (load) begin
        // The load takes priority over a shift in the same cycle.
        // That shift is lost and the upstream word is not taken in.
        for (int k = 0; k < CH_NUM; k++) begin
          sr_reg[CH_NUM-1-k] <= {1'b0, word[k]};
          prev_reg[k]        <= sample[k];
        end
        shift_cnt_reg <= '0;
        busy_reg      <= 1'b1;
        if (busy_reg && (overrun_cnt_reg != {CNT_W{1'b1}})) begin
          overrun_cnt_reg <= overrun_cnt_reg + 1'b1;
        end
      end else if (shift_en) begin
        sr_reg[0] <= data_from_pre;
        for (int k = 1; k < CH_NUM; k++) begin
          sr_reg[k] <= sr_reg[k-1];
        end
        if (shift_cnt_reg != SC_W'(CH_NUM)) begin
          shift_cnt_reg <= shift_cnt_reg + 1'b1;
        end
        if (shift_cnt_reg >= SC_W'(CH_NUM - 1)) begin
          busy_reg <= 1'b0;
        end
      end
    end
  end

  assign data_to_post = sr_reg[CH_NUM-1];
  assign busy         = busy_reg;
  assign overrun_cnt  = overrun_cnt_reg;

endmodule
